dds_pio_ftw_rx: RTL and testbench

- Fabric-side receiver for the 10-bit DDS PIO that the HPS drives.
- The HPS sends a 32-bit frequency tuning word (FTW) as four toggle-strobed bytes. This block reassembles and commits the word.
- A phase accumulator then runs from the committed FTW. Phase MSBs and a wrap pulse go to the downstream sine LUT / DAC path.
- Error and frame status are exported for return to the HPS through an input PIO.

---
 rtl/dds_pio_ftw_rx.sv | 174 +++++++++++++++++
 tb/tb_dds_pio_ftw_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_pio_ftw_rx.sv
// dds_pio_ftw_rx: receives a 32-bit frequency tuning word from the HPS over a
// 10-bit toggle-strobed PIO, commits it, and runs a phase accumulator from it.
// PIO word: [9] toggle strobe, [8] start-of-frame, [7:0] data byte (MSB first).
// Handshake: there is no back-pressure. Each change of the toggle bit offers
// exactly one byte, and the block always accepts it. A word whose toggle bit
// is unchanged is never treated as a new byte.
module dds_pio_ftw_rx #(
    parameter int                 PHASE_W     = 32,
    parameter int                 OUT_W       = 10,
    parameter logic [PHASE_W-1:0] DEFAULT_FTW = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         pio_word,
    input  logic               run,
    output logic [PHASE_W-1:0] ftw,
    output logic [OUT_W-1:0]   phase_out,
    output logic               wrap,
    output logic               frame_done,
    output logic               frame_err,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    // Input stage
    logic [9:0]         pio_q;
    logic               tog_prev;
    logic               primed;
    logic               strobe;

    // Decoded byte stage
    logic               stb_q;
    logic               sof_q;
    logic [7:0]         byte_q;

    // Frame FSM state and byte assembly
    logic [1:0]         byte_cnt;
    logic [1:0]         cnt_next;
    logic [31:0]        sh;
    logic               load_hi;
    logic               load_mid;
    logic               load_lo;
    logic               commit;
    logic               done_d;
    logic               err_d;

    // Phase accumulator
    logic [PHASE_W-1:0] phase_acc;
    logic [PHASE_W:0]   acc_sum;

    assign strobe = primed & (pio_q[9] != tog_prev);

    // Register the PIO word and detect toggle edges. In the priming cycle the
    // edge reference is taken from the level pio_q is about to hold, so a
    // toggle level left over from before reset is never seen as a new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            pio_q    <= '0;
            tog_prev <= 1'b0;
            primed   <= 1'b0;
            stb_q    <= 1'b0;
            sof_q    <= 1'b0;
            byte_q   <= '0;
        end else begin
            pio_q <= pio_word;
            if (!primed) begin
                primed   <= 1'b1;
                tog_prev <= pio_word[9];
            end else begin
                tog_prev <= pio_q[9];
            end
            stb_q  <= strobe;
            sof_q  <= pio_q[8];
            byte_q <= pio_q[7:0];
        end
    end

    // Frame FSM state register (byte_cnt) plus the registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            byte_cnt   <= cnt_next;
            busy       <= (cnt_next != 2'd0);
            frame_done <= done_d;
            frame_err  <= err_d;
            if (err_d && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Frame FSM next-state: SOF always restarts at byte 1, stray data bytes
    // while idle are dropped, the fourth byte returns to idle.
    always_comb begin
        cnt_next = byte_cnt;
        if (stb_q) begin
            if (sof_q) begin
                cnt_next = 2'd1;
            end else if (byte_cnt != 2'd0) begin
                cnt_next = (byte_cnt == 2'd3) ? 2'd0 : byte_cnt + 2'd1;
            end
        end
    end

    // Frame FSM outputs: byte-lane loads, commit and the error/done pulses
    always_comb begin
        load_hi  = 1'b0;
        load_mid = 1'b0;
        load_lo  = 1'b0;
        commit   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (stb_q) begin
            if (sof_q) begin
                load_hi = 1'b1;
                err_d   = (byte_cnt != 2'd0);
            end else begin
                case (byte_cnt)
                    2'd0:    err_d    = 1'b1;
                    2'd1:    load_mid = 1'b1;
                    2'd2:    load_lo  = 1'b1;
                    default: begin
                        commit = 1'b1;
                        done_d = 1'b1;
                    end
                endcase
            end
        end
    end

    // Byte assembly and FTW commit; an SOF discards any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            ftw <= DEFAULT_FTW;
        end else begin
            if (load_hi) begin
                sh <= {byte_q, 24'h000000};
            end
            if (load_mid) begin
                sh[23:16] <= byte_q;
            end
            if (load_lo) begin
                sh[15:8] <= byte_q;
            end
            if (commit) begin
                ftw <= {sh[31:8], byte_q};
            end
        end
    end

    assign acc_sum = {1'b0, phase_acc} + {1'b0, ftw};

    // Phase accumulator; a new FTW never clears phase (phase-continuous switch)
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_acc <= '0;
            wrap      <= 1'b0;
        end else if (run) begin
            phase_acc <= acc_sum[PHASE_W-1:0];
            wrap      <= acc_sum[PHASE_W];
        end else begin
            wrap <= 1'b0;
        end
    end

    assign phase_out = phase_acc[PHASE_W-1 -: OUT_W];

endmodule

// File: tb/tb_dds_pio_ftw_rx.sv
// Bench for dds_pio_ftw_rx: toggle-strobed byte frames against a queue-based
// frame model and an arithmetic phase model.
module tb_dds_pio_ftw_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pio_word;
  logic        run;
  logic [31:0] ftw;
  logic [9:0]  phase_out;
  logic        wrap;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  dds_pio_ftw_rx dut (
    .clk        (clk),
    .reset      (reset),
    .pio_word   (pio_word),
    .run        (run),
    .ftw        (ftw),
    .phase_out  (phase_out),
    .wrap       (wrap),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pulse monitor
  int done_seen = 0;
  int err_seen  = 0;
  always @(negedge clk) begin
    if (frame_done) done_seen++;
    if (frame_err)  err_seen++;
  end

  // reference model
  logic [7:0]  part_q[$];
  logic [31:0] m_ftw;
  int          m_err_cnt;
  int          m_done;
  int          m_err_pulses;
  logic [31:0] m_phase;
  logic        tog;

  function automatic void model_reset();
    part_q.delete();
    m_ftw     = 32'h0;
    m_err_cnt = 0;
    m_phase   = 32'h0;
  endfunction

  function automatic void model_err();
    m_err_pulses++;
    if (m_err_cnt < 255) m_err_cnt++;
  endfunction

  function automatic void model_byte(bit sof, logic [7:0] b);
    if (sof) begin
      if (part_q.size() != 0) model_err();
      part_q.delete();
      part_q.push_back(b);
    end else if (part_q.size() == 0) begin
      model_err();
    end else begin
      part_q.push_back(b);
      if (part_q.size() == 4) begin
        m_ftw = {part_q[0], part_q[1], part_q[2], part_q[3]};
        part_q.delete();
        m_done++;
      end
    end
  endfunction

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(bit sof, logic [7:0] b);
    tog = ~tog;
    pio_word = {tog, sof, b};
    model_byte(sof, b);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(logic [31:0] w);
    send_byte(1'b1, w[31:24]);
    send_byte(1'b0, w[23:16]);
    send_byte(1'b0, w[15:8]);
    send_byte(1'b0, w[7:0]);
  endtask

  task automatic test_reset();
    run = 1'b0;
    tog = 1'b1;
    pio_word = 10'h300;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt got %0h want 0", err_cnt); end
    checks++; if (ftw !== 32'h0) begin errors++; $display("FAIL reset_ftw got %0h want 0", ftw); end
    checks++; if (phase_out !== 10'h0) begin errors++; $display("FAIL reset_phase got %0h want 0", phase_out); end
    checks++; if (err_seen !== 0 || done_seen !== 0) begin errors++; $display("FAIL reset_pulses got err %0d done %0d want 0 0", err_seen, done_seen); end
  endtask

  task automatic test_frame();
    logic [31:0] old_ftw;
    send_byte(1'b1, 8'h12);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy got %0h want 1", busy); end
    send_byte(1'b0, 8'h34);
    send_byte(1'b0, 8'h56);
    old_ftw = m_ftw;
    tog = ~tog;
    pio_word = {tog, 1'b0, 8'h78};
    model_byte(1'b0, 8'h78);
    @(negedge clk);
    @(negedge clk);
    checks++; if (frame_done !== 1'b0 || ftw !== old_ftw) begin errors++; $display("FAIL frame_early got done %0h ftw %0h want 0 %0h", frame_done, ftw, old_ftw); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse got %0h want 1", frame_done); end
    checks++; if (ftw !== 32'h12345678) begin errors++; $display("FAIL frame_ftw got %0h want 12345678", ftw); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL frame_after got done %0h busy %0h want 0 0", frame_done, busy); end
    repeat (2) @(negedge clk);
    checks++; if (done_seen !== m_done || err_cnt !== 8'h00) begin errors++; $display("FAIL frame_counts got done %0d err_cnt %0h want %0d 0", done_seen, err_cnt, m_done); end
  endtask

  task automatic run_phase(int n);
    logic [32:0] sum;
    int bad = 0;
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sum = {1'b0, m_phase} + {1'b0, m_ftw};
      m_phase = sum[31:0];
      checks++;
      if (phase_out !== m_phase[31:22] || wrap !== sum[32]) begin
        errors++;
        $display("FAIL phase_run cyc %0d got phase %0h wrap %0h want %0h %0h", i, phase_out, wrap, m_phase[31:22], sum[32]);
      end
    end
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (phase_out !== m_phase[31:22] || wrap !== 1'b0) begin
        errors++;
        $display("FAIL phase_hold cyc %0d got phase %0h wrap %0h want %0h 0", i, phase_out, wrap, m_phase[31:22]);
      end
    end
  endtask

  task automatic test_phase();
    do_reset();
    send_frame(32'h40000000);
    checks++; if (ftw !== 32'h40000000) begin errors++; $display("FAIL phase_ftw got %0h want 40000000", ftw); end
    run_phase(12);
    send_frame($urandom);
    checks++; if (ftw !== m_ftw) begin errors++; $display("FAIL phase_ftw2 got %0h want %0h", ftw, m_ftw); end
    run_phase(20);
    send_frame(32'h0);
    run_phase(6);
  endtask

  task automatic test_errors();
    do_reset();
    send_byte(1'b0, 8'h99);
    checks++; if (err_cnt !== 8'd1 || err_seen !== m_err_pulses) begin errors++; $display("FAIL err_stray got cnt %0h pulses %0d want 1 %0d", err_cnt, err_seen, m_err_pulses); end
    checks++; if (ftw !== 32'h0) begin errors++; $display("FAIL err_stray_ftw got %0h want 0", ftw); end
    send_byte(1'b1, 8'hAA);
    send_byte(1'b0, 8'hBB);
    send_frame(32'h01020304);
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL err_restart_cnt got %0h want 2", err_cnt); end
    checks++; if (ftw !== 32'h01020304) begin errors++; $display("FAIL err_restart_ftw got %0h want 01020304", ftw); end
    checks++; if (err_seen !== m_err_pulses || done_seen !== m_done) begin errors++; $display("FAIL err_pulses got %0d %0d want %0d %0d", err_seen, done_seen, m_err_pulses, m_done); end
  endtask

  task automatic test_random();
    bit          sof;
    logic [7:0]  b;
    int          bad = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      sof = ($urandom_range(0, 3) == 0);
      b = 8'($urandom);
      send_byte(sof, b);
      checks++;
      if (ftw !== m_ftw || err_cnt !== 8'(m_err_cnt) || busy !== (part_q.size() != 0)) begin
        errors++;
        $display("FAIL random_%0d got ftw %0h cnt %0h busy %0h want %0h %0h %0h", i, ftw, err_cnt, busy, m_ftw, 8'(m_err_cnt), (part_q.size() != 0));
      end
    end
    checks++; if (done_seen !== m_done || err_seen !== m_err_pulses) begin errors++; $display("FAIL random_pulses got %0d %0d want %0d %0d", done_seen, err_seen, m_done, m_err_pulses); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) send_byte(1'b0, 8'($urandom));
    checks++; if (err_cnt !== 8'hFF || m_err_cnt != 255) begin errors++; $display("FAIL sat_cnt got %0h want ff", err_cnt); end
    pio_word = {tog, 1'b1, 8'h55};
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0 || err_seen !== m_err_pulses || err_cnt !== 8'hFF) begin errors++; $display("FAIL no_toggle got busy %0h pulses %0d cnt %0h want 0 %0d ff", busy, err_seen, m_err_pulses, err_cnt); end
    send_byte(1'b1, 8'h55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_sof_busy got %0h want 1", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(32'hABCDEF01);
    checks++; if (ftw !== 32'hABCDEF01) begin errors++; $display("FAIL mid_pre_ftw got %0h want abcdef01", ftw); end
    send_byte(1'b1, 8'h11);
    send_byte(1'b0, 8'h22);
    do_reset();
    send_byte(1'b0, 8'h33);
    send_byte(1'b0, 8'h44);
    checks++; if (ftw !== 32'h0) begin errors++; $display("FAIL mid_ftw got %0h want 0", ftw); end
    checks++; if (err_cnt !== 8'd2 || err_seen !== m_err_pulses) begin errors++; $display("FAIL mid_err got cnt %0h pulses %0d want 2 %0d", err_cnt, err_seen, m_err_pulses); end
    checks++; if (done_seen !== m_done || busy !== 1'b0) begin errors++; $display("FAIL mid_done got done %0d busy %0h want %0d 0", done_seen, busy, m_done); end
  endtask

  initial begin
    m_done = 0;
    m_err_pulses = 0;
    test_reset();
    test_frame();
    test_phase();
    test_errors();
    test_random();
    test_saturation();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
